// File: rtl/uart_rx_line_monitor.sv
// Purpose: UART receiver (runtime divisor/width/parity) that groups bytes into lines
//          and delivers them through a FWFT byte FIFO with an end-of-line flag.
// Latency: byte pushed at the end of the stop-sample tick cycle S; m_valid_o from S+1.
// Backpressure: m_ready_i pops the FIFO head; a commit into a full FIFO (without a
//          same-cycle pop) drops the byte and sets the sticky overflow flag.
// Ports: clk_i/rst_i (async active-high), uart_rx_i serial in, cfg_* frame format,
//          m_* byte stream, line_count_o complete lines buffered, sticky error flags
//          with clr_err_i.
module uart_rx_line_monitor #(
    parameter int FifoDepth  = 16,
    parameter int MaxLineLen = 80,
    parameter int DivWidth   = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         uart_rx_i,
    input  logic [DivWidth-1:0]          cfg_div_i,
    input  logic [1:0]                   cfg_bits_i,
    input  logic                         cfg_parity_en_i,
    input  logic                         cfg_parity_odd_i,
    output logic [7:0]                   m_data_o,
    output logic                         m_last_o,
    output logic                         m_valid_o,
    input  logic                         m_ready_i,
    output logic [$clog2(FifoDepth):0]   line_count_o,
    output logic                         parity_err_o,
    output logic                         frame_err_o,
    output logic                         overflow_o,
    input  logic                         clr_err_i
);
    localparam int PtrW = $clog2(FifoDepth);
    localparam int LenW = $clog2(MaxLineLen + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic                rx_meta_q, rx_s_q;
    state_t              state_q, state_d;
    logic [DivWidth-1:0] div_cnt_q, div_cnt_d;
    logic [DivWidth-1:0] div_q, div_d;
    logic [3:0]          tick_cnt_q, tick_cnt_d;
    logic [2:0]          bit_idx_q, bit_idx_d;
    logic [1:0]          nbits_q, nbits_d;
    logic                par_en_q, par_en_d;
    logic                par_odd_q, par_odd_d;
    logic [7:0]          shreg_q, shreg_d;
    logic                bad_q, bad_d;
    logic [LenW-1:0]     line_len_q, line_len_d;
    logic                par_err_q, par_err_d;
    logic                frm_err_q, frm_err_d;
    logic                ovf_q, ovf_d;
    logic [PtrW:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrW:0]       rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]       line_cnt_q, line_cnt_d;
    logic [8:0]          mem_q [FifoDepth];

    logic tick;
    logic commit, par_set, frm_set;
    logic commit_last;
    logic full, empty, push, pop;
    logic [8:0] head;

    // Two-flop synchronizer; idles high so reset never looks like a start bit.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= uart_rx_i;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Oversample tick; the counter is held at 0 in IDLE so the first tick
    // after the start edge lands exactly div_q cycles later.
    assign tick = (state_q != S_IDLE) && (div_cnt_q == div_q - DivWidth'(1));

    // ------------------------------------------------------------------
    // RX FSM (next state)
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        div_cnt_d  = div_cnt_q;
        div_d      = div_q;
        tick_cnt_d = tick_cnt_q;
        bit_idx_d  = bit_idx_q;
        nbits_d    = nbits_q;
        par_en_d   = par_en_q;
        par_odd_d  = par_odd_q;
        shreg_d    = shreg_q;
        bad_d      = bad_q;
        commit     = 1'b0;
        par_set    = 1'b0;
        frm_set    = 1'b0;

        if (state_q == S_IDLE) begin
            div_cnt_d = '0;
        end else if (tick) begin
            div_cnt_d = '0;
        end else begin
            div_cnt_d = div_cnt_q + DivWidth'(1);
        end

        case (state_q)
            S_IDLE: begin
                tick_cnt_d = '0;
                if (!rx_s_q) begin
                    // Frame format is captured here so mid-frame cfg edits are ignored.
                    state_d   = S_START;
                    div_d     = (cfg_div_i == '0) ? DivWidth'(1) : cfg_div_i;
                    nbits_d   = cfg_bits_i;
                    par_en_d  = cfg_parity_en_i;
                    par_odd_d = cfg_parity_odd_i;
                    shreg_d   = '0;
                    bad_d     = 1'b0;
                    bit_idx_d = '0;
                end
            end
            S_START: begin
                if (tick) begin
                    if (tick_cnt_q == 4'd7) begin
                        tick_cnt_d = '0;
                        state_d    = rx_s_q ? S_IDLE : S_DATA;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (tick_cnt_q == 4'd15) begin
                        tick_cnt_d         = '0;
                        shreg_d[bit_idx_q] = rx_s_q;
                        if (bit_idx_q == ({1'b0, nbits_q} + 3'd4)) begin
                            state_d = par_en_q ? S_PARITY : S_STOP;
                        end else begin
                            bit_idx_d = bit_idx_q + 3'd1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
            end
            S_PARITY: begin
                if (tick) begin
                    if (tick_cnt_q == 4'd15) begin
                        tick_cnt_d = '0;
                        state_d    = S_STOP;
                        // Unused high data bits are zero, so a full-width XOR is safe.
                        if (((^shreg_q) ^ rx_s_q) != par_odd_q) begin
                            par_set = 1'b1;
                            bad_d   = 1'b1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (tick_cnt_q == 4'd15) begin
                        tick_cnt_d = '0;
                        state_d    = S_IDLE;
                        if (!rx_s_q) begin
                            frm_set = 1'b1;
                        end else if (!bad_q) begin
                            commit = 1'b1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO control, line tracking, sticky errors
    // ------------------------------------------------------------------
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                   (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
    assign pop   = !empty && m_ready_i;
    // A pop in the same cycle frees the slot, so full+pop still accepts.
    assign push  = commit && (!full || pop);
    assign head  = mem_q[rd_ptr_q[PtrW-1:0]];

    assign commit_last = (shreg_q == 8'h0A) || (line_len_q == LenW'(MaxLineLen - 1));

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        line_len_d = line_len_q;
        line_cnt_d = line_cnt_q;
        if (push) begin
            wr_ptr_d   = wr_ptr_q + 1'b1;
            line_len_d = commit_last ? '0 : line_len_q + LenW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push && commit_last, pop && head[8]})
            2'b10:   line_cnt_d = line_cnt_q + 1'b1;
            2'b01:   line_cnt_d = line_cnt_q - 1'b1;
            default: line_cnt_d = line_cnt_q;
        endcase
        // Set events win over a simultaneous clear.
        par_err_d = par_set | (par_err_q & ~clr_err_i);
        frm_err_d = frm_set | (frm_err_q & ~clr_err_i);
        ovf_d     = (commit && !push) | (ovf_q & ~clr_err_i);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            div_cnt_q  <= '0;
            div_q      <= DivWidth'(1);
            tick_cnt_q <= '0;
            bit_idx_q  <= '0;
            nbits_q    <= '0;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            shreg_q    <= '0;
            bad_q      <= 1'b0;
            line_len_q <= '0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
            ovf_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            line_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            div_q      <= div_d;
            tick_cnt_q <= tick_cnt_d;
            bit_idx_q  <= bit_idx_d;
            nbits_q    <= nbits_d;
            par_en_q   <= par_en_d;
            par_odd_q  <= par_odd_d;
            shreg_q    <= shreg_d;
            bad_q      <= bad_d;
            line_len_q <= line_len_d;
            par_err_q  <= par_err_d;
            frm_err_q  <= frm_err_d;
            ovf_q      <= ovf_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            line_cnt_q <= line_cnt_d;
        end
    end

    // Storage needs no reset: the empty flag masks stale entries.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q[PtrW-1:0]] <= {commit_last, shreg_q};
        end
    end

    assign m_valid_o    = !empty;
    assign m_data_o     = empty ? 8'h00 : head[7:0];
    assign m_last_o     = empty ? 1'b0  : head[8];
    assign line_count_o = line_cnt_q;
    assign parity_err_o = par_err_q;
    assign frame_err_o  = frm_err_q;
    assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_uart_rx_line_monitor.sv
module tb_uart_rx_line_monitor;
    localparam int FifoDepth  = 4;
    localparam int MaxLineLen = 4;
    localparam int DivWidth   = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic                uart_rx;
    logic [DivWidth-1:0] cfg_div;
    logic [1:0]          cfg_bits;
    logic                cfg_pen;
    logic                cfg_podd;
    logic [7:0]          m_data;
    logic                m_last;
    logic                m_valid;
    logic                m_ready;
    logic [2:0]          line_count;
    logic                parity_err;
    logic                frame_err;
    logic                overflow;
    logic                clr_err;

    int n_cmp = 0;
    int n_bad = 0;
    logic [8:0] exp_q[$];

    always #5 clk = ~clk;

    uart_rx_line_monitor #(
        .FifoDepth (FifoDepth),
        .MaxLineLen(MaxLineLen),
        .DivWidth  (DivWidth)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .uart_rx_i       (uart_rx),
        .cfg_div_i       (cfg_div),
        .cfg_bits_i      (cfg_bits),
        .cfg_parity_en_i (cfg_pen),
        .cfg_parity_odd_i(cfg_podd),
        .m_data_o        (m_data),
        .m_last_o        (m_last),
        .m_valid_o       (m_valid),
        .m_ready_i       (m_ready),
        .line_count_o    (line_count),
        .parity_err_o    (parity_err),
        .frame_err_o     (frame_err),
        .overflow_o      (overflow),
        .clr_err_i       (clr_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge, well away from sampling.
    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One frame: start, nbits LSB-first, optional parity bit, stop.
    // A bad stop bit is held low for 9 ticks only, then the line idles high.
    task automatic send_frame(input logic [7:0] d, input int nbits, input int div,
                              input bit par_en, input bit pbit, input bit stop_ok);
        uart_rx = 1'b0;
        hold(16 * div);
        for (int i = 0; i < nbits; i++) begin
            uart_rx = d[i];
            hold(16 * div);
        end
        if (par_en) begin
            uart_rx = pbit;
            hold(16 * div);
        end
        if (stop_ok) begin
            uart_rx = 1'b1;
            hold(16 * div);
        end else begin
            uart_rx = 1'b0;
            hold(9 * div);
            uart_rx = 1'b1;
            hold(32 * div);
        end
    endtask

    task automatic wait_empty(input string name);
        int i;
        i = 0;
        while (m_valid && i < 200) begin
            hold(1);
            i++;
        end
        check(name, 32'(m_valid), 0);
    endtask

    task automatic clear_errors();
        clr_err = 1'b1;
        hold(1);
        clr_err = 1'b0;
    endtask

    // Scoreboard monitor: every accepted byte is matched against the queue.
    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL pop_unexpected: got %0h, expected no byte", m_data);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                check("pop_data", 32'(m_data), 32'(e[7:0]));
                check("pop_last", 32'(m_last), 32'(e[8]));
            end
        end
    end

    initial begin
        rst      = 1'b1;
        uart_rx  = 1'b1;
        m_ready  = 1'b0;
        clr_err  = 1'b0;
        cfg_div  = 16'd1;
        cfg_bits = 2'd3;
        cfg_pen  = 1'b0;
        cfg_podd = 1'b0;
        hold(3);
        check("rst_valid", 32'(m_valid), 0);
        check("rst_data", 32'(m_data), 0);
        check("rst_lcount", 32'(line_count), 0);
        check("rst_errs", {29'd0, parity_err, frame_err, overflow}, 0);
        rst = 1'b0;
        hold(4);

        // 1: single byte, 8N1, D=1, consumer stalled
        exp_q.push_back({1'b0, 8'h41});
        fork
            send_frame(8'h41, 8, 1, 1'b0, 1'b0, 1'b1);
            begin
                hold(144);
                check("t1_valid_before_stop", 32'(m_valid), 0);
                hold(16);
                check("t1_valid_after_stop", 32'(m_valid), 1);
            end
        join
        hold(20);
        check("t1_data", 32'(m_data), 32'h41);
        check("t1_last", 32'(m_last), 0);
        check("t1_lcount", 32'(line_count), 0);
        m_ready = 1'b1;
        hold(1);
        check("t1_single_entry", 32'(m_valid), 0);
        m_ready = 1'b0;

        // 2: "Hi\n"
        exp_q.push_back({1'b0, 8'h48});
        exp_q.push_back({1'b0, 8'h69});
        exp_q.push_back({1'b1, 8'h0A});
        send_frame(8'h48, 8, 1, 1'b0, 1'b0, 1'b1);
        send_frame(8'h69, 8, 1, 1'b0, 1'b0, 1'b1);
        send_frame(8'h0A, 8, 1, 1'b0, 1'b0, 1'b1);
        hold(4);
        check("t2_lcount", 32'(line_count), 1);
        check("t2_head", 32'(m_data), 32'h48);
        m_ready = 1'b1;
        wait_empty("t2_drain");
        check("t2_lcount_after", 32'(line_count), 0);
        m_ready = 1'b0;

        // 3: forced end-of-line at MaxLineLen=4
        exp_q.push_back({1'b0, 8'h30});
        exp_q.push_back({1'b0, 8'h31});
        exp_q.push_back({1'b0, 8'h32});
        exp_q.push_back({1'b1, 8'h33});
        for (int b = 0; b < 4; b++) send_frame(8'h30 + 8'(b), 8, 1, 1'b0, 1'b0, 1'b1);
        hold(4);
        check("t3_lcount", 32'(line_count), 1);
        check("t3_ovf", 32'(overflow), 0);
        m_ready = 1'b1;
        wait_empty("t3_drain1");
        exp_q.push_back({1'b0, 8'h34});
        exp_q.push_back({1'b0, 8'h35});
        exp_q.push_back({1'b0, 8'h36});
        exp_q.push_back({1'b1, 8'h37});
        for (int b = 4; b < 8; b++) send_frame(8'h30 + 8'(b), 8, 1, 1'b0, 1'b0, 1'b1);
        wait_empty("t3_drain2");
        check("t3_lcount_end", 32'(line_count), 0);

        // 4: 7E1 at D=4 -- good byte, bad parity, bad stop, clear
        cfg_div  = 16'd4;
        cfg_bits = 2'd2;
        cfg_pen  = 1'b1;
        cfg_podd = 1'b0;
        exp_q.push_back({1'b0, 8'h55});
        send_frame(8'h55, 7, 4, 1'b1, 1'b0, 1'b1);
        hold(4);
        wait_empty("t4_good_drain");
        check("t4_no_perr", 32'(parity_err), 0);
        send_frame(8'h55, 7, 4, 1'b1, 1'b1, 1'b1);
        hold(4);
        check("t4_perr", 32'(parity_err), 1);
        check("t4_perr_nopush", 32'(m_valid), 0);
        check("t4_no_ferr", 32'(frame_err), 0);
        send_frame(8'h55, 7, 4, 1'b1, 1'b0, 1'b0);
        check("t4_ferr", 32'(frame_err), 1);
        check("t4_ferr_nopush", 32'(m_valid), 0);
        clear_errors();
        check("t4_clr", {30'd0, parity_err, frame_err}, 0);
        m_ready = 1'b0;

        // 5: overflow with depth 4
        cfg_div  = 16'd1;
        cfg_bits = 2'd3;
        cfg_pen  = 1'b0;
        exp_q.push_back({1'b0, 8'h61});
        exp_q.push_back({1'b0, 8'h62});
        exp_q.push_back({1'b1, 8'h63});
        exp_q.push_back({1'b0, 8'h64});
        for (int b = 0; b < 5; b++) send_frame(8'h61 + 8'(b), 8, 1, 1'b0, 1'b0, 1'b1);
        hold(4);
        check("t5_ovf", 32'(overflow), 1);
        check("t5_head", 32'(m_data), 32'h61);
        check("t5_lcount", 32'(line_count), 1);
        m_ready = 1'b1;
        wait_empty("t5_drain");
        m_ready = 1'b0;
        clear_errors();
        check("t5_ovf_clr", 32'(overflow), 0);

        // 6: glitch at D=3, then reset mid-frame
        cfg_div = 16'd3;
        uart_rx = 1'b0;
        hold(12);
        uart_rx = 1'b1;
        hold(100);
        check("t6_glitch_nobyte", 32'(m_valid), 0);
        check("t6_glitch_noerr", {30'd0, parity_err, frame_err}, 0);
        exp_q.push_back({1'b0, 8'h70});
        send_frame(8'h70, 8, 3, 1'b0, 1'b0, 1'b1);
        hold(4);
        check("t6_pre_rst_valid", 32'(m_valid), 1);
        uart_rx = 1'b0;
        hold(16 * 3 * 3);
        rst = 1'b1;
        hold(2);
        check("t6_rst_valid", 32'(m_valid), 0);
        check("t6_rst_data", 32'(m_data), 0);
        check("t6_rst_lcount", 32'(line_count), 0);
        exp_q.delete();
        uart_rx = 1'b1;
        hold(2);
        rst = 1'b0;
        hold(4);
        exp_q.push_back({1'b1, 8'h0A});
        send_frame(8'h0A, 8, 3, 1'b0, 1'b0, 1'b1);
        hold(4);
        check("t6_data", 32'(m_data), 32'h0A);
        check("t6_last", 32'(m_last), 1);
        check("t6_lcount", 32'(line_count), 1);
        m_ready = 1'b1;
        wait_empty("t6_drain");
        check("t6_errs", {29'd0, parity_err, frame_err, overflow}, 0);

        check("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_rx_line_monitor.md
# uart_rx_line_monitor

Synthesizable successor to the bench-side UART line reader. It receives serial frames on one UART input with a runtime-programmable baud divisor, data width and parity. It groups received bytes into lines, ending a line on newline (0x0A) or on a maximum line length. Lines are delivered through a valid/ready byte stream with an end-of-line flag. It sits next to the SoC UART TX pin, in the on-chip debug/observability path or in an FPGA test harness, so line capture no longer depends on simulation-only tasks.

## Interface
- `FifoDepth`, default 16: byte FIFO entries, power of two, ≥2.
- `MaxLineLen`, default 80: bytes per line before forced end-of-line, ≥1.
- `DivWidth`, default 16: width of the baud divisor.
- `clk_i`  in  1: system clock.
- `rst_i`  in  1: asynchronous reset, active-high.
- `uart_rx_i`  in  1: serial input, idle high, asynchronous.
- `cfg_div_i`  in  DivWidth: clock cycles per 16x oversample tick; 0 is treated as 1.
- `cfg_bits_i`  in  2: data bits minus 5 (0→5 … 3→8).
- `cfg_parity_en_i`  in  1: parity bit present.
- `cfg_parity_odd_i`  in  1: 1 = odd parity, 0 = even.
- `m_data_o`  out  8: received byte, zero-extended when fewer than 8 data bits.
- `m_last_o`  out  1: byte ends a line.
- `m_valid_o`  out  1: FIFO head valid.
- `m_ready_i`  in  1: consumer accepts head.
- `line_count_o`  out  $clog2(FifoDepth)+1: complete lines in the FIFO.
- `parity_err_o`  out  1: sticky parity error.
- `frame_err_o`  out  1: sticky framing error.
- `overflow_o`  out  1: sticky FIFO overflow.
- `clr_err_i`  in  1: clears all sticky errors.

## Operation
- **Input conditioning:** `uart_rx_i` passes through a 2-flop synchronizer, which resets to 1. All logic uses the synchronized value `rx_s`.
- **Tick generator:** a counter emits a 1-cycle tick every max(`cfg_div_i`,1) cycles. It restarts at 0 on leaving IDLE so that sampling is phase-aligned to the start edge.
- **RX FSM states:**
  - IDLE: on `rx_s`==0, go to START.
  - START: after 8 ticks (mid-bit), if `rx_s`==0 go to DATA; otherwise the start is treated as a glitch and the FSM returns to IDLE with no error.
  - DATA: sample every 16 ticks, LSB first, `cfg_bits_i`+5 bits. Then go to PARITY if enabled, else STOP.
  - PARITY: sample after 16 ticks. Mismatch sets the sticky parity error and marks the byte bad. The check is that the XOR of the data bits and the parity bit equals `cfg_parity_odd_i`.
  - STOP: sample after 16 ticks. A sample of 0 sets `frame_err_o` and marks the byte bad. In both cases the FSM returns to IDLE.
- **Byte commit:** a byte marked bad is discarded and does not advance the line counter. A good byte is pushed with last = (byte==0x0A) || (line_len+1 == `MaxLineLen`).
  - `line_len` resets to 0 after a push with last=1, otherwise increments on each push.
- **Overflow:** if the FIFO is full at commit, the byte is dropped, `overflow_o` is set, `line_len` is unchanged and FIFO contents are unchanged.
- **FIFO:** first-word-fall-through. Pop when `m_valid_o` && `m_ready_i`.
- **line_count_o:** +1 on push with last, −1 on pop with last. Both in the same cycle leaves it unchanged.
- **Sticky errors:** `clr_err_i` clears them. A set event in the same cycle as `clr_err_i` wins, so the flag stays 1.
- **Config changes:** changing `cfg_*` mid-frame is unsupported. Changes take effect only from IDLE.

## Timing
- **Reset values:** all outputs 0, `rx_s`=1, FSM=IDLE, FIFO empty, `line_len`=0. Reset mid-frame discards the partial byte. Reset does not touch delivered data beyond emptying the FIFO.
- **Bit period:** 16×D clk cycles with D = max(`cfg_div_i`,1). The start edge is seen 2 cycles after the pin changes because of the synchronizer.
- **Commit latency:** the push occurs at the end of the stop-sample tick cycle S. `m_valid_o` and `line_count_o` update from cycle S+1.
- **Pop:** `m_data_o`/`m_last_o` show the next entry in the cycle after a handshake.
- **Empty/full:** push and pop may occur in the same cycle. When full, a simultaneous pop and push is accepted with no overflow.
- **Pointers:** read and write pointers wrap modulo `FifoDepth`. Full and empty are distinguished by an extra pointer bit.

## Test plan
1. D=1, 8N1, send 0x41, `m_ready_i`=0 → exactly 1 entry: `m_data_o`=0x41, `m_last_o`=0, `line_count_o`=0; `m_valid_o` rises in cycle S+1.
2. Send "Hi\n" (0x48,0x69,0x0A) → 3 entries, last only on 0x0A. `line_count_o`=1, and it returns to 0 on the cycle after 0x0A is popped.
3. `MaxLineLen`=4, send 6 bytes 0x30..0x35 without newline → last on 0x33 only, `line_count_o`=1; 0x34/0x35 belong to the next line.
4. Even parity, 7 data bits: send 0x55 with correct parity → accepted as 0x55. Send with flipped parity → `parity_err_o`=1, no push. A stop bit of 0 → `frame_err_o`=1, no push. `clr_err_i` → both 0.
5. `FifoDepth`=4, `m_ready_i`=0, send 5 bytes → first 4 kept, `overflow_o`=1, head is still byte 1. Pop all 4 → data matches, `m_valid_o` drops.
6. D=3: a low pulse lasting 4 ticks → no byte, no error. Assert `rst_i` mid-frame, release it, send 0x0A → outputs 0 during reset, then one entry 0x0A with last=1.
